// File: rtl/pixel_coord_pkg.sv
// Shared types and helpers for the pixel coordinate tracker.
// The FSM states are IDLE, ACTIVE and DONE; the helpers size a line in beats.
package pixel_coord_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_IM_WIDTH    = 640;
  localparam int DEF_PIX_PER_CLK = 1;
  localparam int BEATS_PER_LINE  = DEF_IM_WIDTH / DEF_PIX_PER_CLK;

  function automatic int beats_per_line(input int im_width, input int pix_per_clk);
    return im_width / pix_per_clk;
  endfunction

endpackage

// File: rtl/sig_delay_line.sv
// Fixed-depth shift register that carries a small bundle of control bits.
// With DEPTH=0 it collapses to a plain wire.
module sig_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/pixel_coord_tracker.sv
// Tracks the (x, y) position of each pixel beat after a fixed upstream latency
// and flags line/frame boundaries, completed frames and framing errors.
//
//   state  | meaning
//   IDLE   | after reset, waiting for the first start of frame
//   ACTIVE | inside a frame, counting beats
//   DONE   | last beat of the frame seen, waiting for the next start of frame
module pixel_coord_tracker
  import pixel_coord_pkg::*;
#(
  parameter int IM_WIDTH    = 640,
  parameter int IM_HEIGHT   = 480,
  parameter int PROP_DELAY  = 0,
  parameter int PIX_PER_CLK = 1,
  parameter int IND_WIDTH   = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_frame,
  input  logic                 pix_valid,
  output logic [IND_WIDTH-1:0] ind_x,
  output logic [IND_WIDTH-1:0] ind_y,
  output logic                 coord_valid,
  output logic                 sof_out,
  output logic                 eol_out,
  output logic                 eof_out,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 err_short,
  output logic                 err_overflow
);

  if (PIX_PER_CLK != 1 && PIX_PER_CLK != 2 && PIX_PER_CLK != 4) begin : g_bad_ppc
    $error("PIX_PER_CLK must be 1, 2 or 4");
  end
  if (IM_WIDTH % PIX_PER_CLK != 0) begin : g_bad_div
    $error("IM_WIDTH must be a multiple of PIX_PER_CLK");
  end
  if (longint'(IM_WIDTH) > (longint'(1) << IND_WIDTH) ||
      longint'(IM_HEIGHT) > (longint'(1) << IND_WIDTH)) begin : g_bad_ind
    $error("IM_WIDTH-1 or IM_HEIGHT-1 does not fit in IND_WIDTH bits");
  end
  if (PROP_DELAY < 0 || PROP_DELAY > 1023) begin : g_bad_delay
    $error("PROP_DELAY must be within 0..1023");
  end

  localparam int BPL = beats_per_line(IM_WIDTH, PIX_PER_CLK);
  localparam logic [IND_WIDTH-1:0] LAST_X = IND_WIDTH'((BPL - 1) * PIX_PER_CLK);
  localparam logic [IND_WIDTH-1:0] LAST_Y = IND_WIDTH'(IM_HEIGHT - 1);
  localparam logic [IND_WIDTH-1:0] STEP_X = IND_WIDTH'(PIX_PER_CLK);

  logic d_valid;
  logic d_sof;

  sig_delay_line #(
    .WIDTH (2),
    .DEPTH (PROP_DELAY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({pix_valid, new_frame & pix_valid}),
    .dout ({d_valid, d_sof})
  );

  state_t               state, state_n;
  logic [IND_WIDTH-1:0] x_n, y_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic                 cv_n, sof_n, eol_n, eof_n, es_n, eo_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ind_x        <= '0;
      ind_y        <= '0;
      coord_valid  <= 1'b0;
      sof_out      <= 1'b0;
      eol_out      <= 1'b0;
      eof_out      <= 1'b0;
      frame_cnt    <= '0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      ind_x        <= x_n;
      ind_y        <= y_n;
      coord_valid  <= cv_n;
      sof_out      <= sof_n;
      eol_out      <= eol_n;
      eof_out      <= eof_n;
      frame_cnt    <= cnt_n;
      err_short    <= es_n;
      err_overflow <= eo_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = ind_x;
    y_n     = ind_y;
    cnt_n   = frame_cnt;
    cv_n    = 1'b0;
    sof_n   = 1'b0;
    eol_n   = 1'b0;
    eof_n   = 1'b0;
    es_n    = 1'b0;
    eo_n    = 1'b0;

    if (d_valid && d_sof) begin
      x_n   = '0;
      y_n   = '0;
      cv_n  = 1'b1;
      sof_n = 1'b1;
      es_n  = (state == ACTIVE);
      eol_n = (LAST_X == '0);
      eof_n = eol_n && (LAST_Y == '0);
      state_n = ACTIVE;
    end else if (d_valid) begin
      case (state)
        ACTIVE: begin
          // Wrap to the next line once the previous beat closed a line.
          if (ind_x == LAST_X) begin
            x_n = '0;
            y_n = ind_y + IND_WIDTH'(1);
          end else begin
            x_n = ind_x + STEP_X;
          end
          cv_n  = 1'b1;
          eol_n = (x_n == LAST_X);
          eof_n = eol_n && (y_n == LAST_Y);
        end
        DONE:    eo_n = 1'b1;
        default: ;
      endcase
    end

    // A frame only counts once its final beat has been emitted.
    if (eof_n) begin
      state_n = DONE;
      cnt_n   = frame_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pixel_coord_tracker.sv
// Directed bench: stimulus pushes expected beats into a scoreboard queue and a
// negedge monitor pops and compares each time the tracker emits something.
module tb_pixel_coord_tracker;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int PPC = 2;
  localparam int PD  = 3;
  localparam int BPL = W / PPC;
  localparam int BPF = BPL * H;

  typedef struct {
    int          cyc;
    logic [11:0] x;
    logic [11:0] y;
    logic        cv, sof, eol, eof, es, eo;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_frame = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] ind_x, ind_y;
  logic        coord_valid, sof_out, eol_out, eof_out, err_short, err_overflow;
  logic [15:0] frame_cnt;

  logic        nf2 = 1'b0;
  logic        pv2 = 1'b0;
  logic [11:0] x2, y2;
  logic        cv2, sof2, eol2, eof2, es2, eo2;
  logic [15:0] cnt2;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rst_q = 1'b1;
  exp_t sb[$];
  logic [11:0] last_x = '0, last_y = '0;
  logic [15:0] last_cnt = '0;

  pixel_coord_tracker #(
    .IM_WIDTH(W), .IM_HEIGHT(H), .PROP_DELAY(PD), .PIX_PER_CLK(PPC),
    .IND_WIDTH(12), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .pix_valid(pix_valid),
    .ind_x(ind_x), .ind_y(ind_y), .coord_valid(coord_valid),
    .sof_out(sof_out), .eol_out(eol_out), .eof_out(eof_out),
    .frame_cnt(frame_cnt), .err_short(err_short), .err_overflow(err_overflow)
  );

  pixel_coord_tracker #(
    .IM_WIDTH(1), .IM_HEIGHT(1), .PROP_DELAY(0), .PIX_PER_CLK(1),
    .IND_WIDTH(12), .CNT_WIDTH(16)
  ) dut2 (
    .clk(clk), .rst(rst), .new_frame(nf2), .pix_valid(pv2),
    .ind_x(x2), .ind_y(y2), .coord_valid(cv2),
    .sof_out(sof2), .eol_out(eol2), .eof_out(eof2),
    .frame_cnt(cnt2), .err_short(es2), .err_overflow(eo2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event must match the oldest expectation; quiet
  // cycles must hold the last emitted indices and count.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      last_x   = '0;
      last_y   = '0;
      last_cnt = '0;
    end else if (coord_valid | sof_out | eol_out | eof_out | err_short | err_overflow) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {ind_x, ind_y, coord_valid, err_overflow}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("sb_cycle", 64'(cyc), 64'(e.cyc));
        chk("sb_beat",
            {ind_x, ind_y, coord_valid, sof_out, eol_out, eof_out, err_short, err_overflow, frame_cnt},
            {e.x, e.y, e.cv, e.sof, e.eol, e.eof, e.es, e.eo, e.cnt});
        last_x   = e.x;
        last_y   = e.y;
        last_cnt = e.cnt;
      end
    end else begin
      chk("hold", {ind_x, ind_y, frame_cnt}, {last_x, last_y, last_cnt});
    end
  end

  task automatic drive(input bit nf, input bit pv);
    @(posedge clk);
    #1;
    new_frame = nf;
    pix_valid = pv;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0);
  endtask

  task automatic push_exp(input logic [11:0] x, input logic [11:0] y, input logic cv,
                          input logic sof, input logic eol, input logic eof,
                          input logic es, input logic eo, input logic [15:0] cnt);
    exp_t e;
    e.cyc = cyc + PD + 1;
    e.x = x; e.y = y; e.cv = cv; e.sof = sof; e.eol = eol; e.eof = eof;
    e.es = es; e.eo = eo; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Beats 0..n-1 of a frame, new_frame on beat 0; only the first n_push are expected out.
  task automatic send_run(input int n, input int cnt_before, input bit es_first,
                          input bit gap, input int n_push);
    for (int k = 0; k < n; k++) begin
      drive(k == 0, 1'b1);
      if (k < n_push)
        push_exp(12'((k % BPL) * PPC), 12'(k / BPL), 1'b1, k == 0,
                 (k % BPL) == BPL - 1, k == BPF - 1, es_first && k == 0, 1'b0,
                 16'(cnt_before + ((k == BPF - 1) ? 1 : 0)));
      if (gap) drive(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    new_frame = 1'b0;
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {ind_x, ind_y, coord_valid, sof_out, eol_out, eof_out, err_short, err_overflow, frame_cnt},
        64'h0);
    chk("reset_outputs2",
        {x2, y2, cv2, sof2, eol2, eof2, es2, eo2, cnt2}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Beats before any new_frame: no outputs, no errors.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    idle(6);

    // Full contiguous frame.
    send_run(BPF, 0, 1'b0, 1'b0, BPF);
    idle(6);
    @(negedge clk);
    chk("frame_cnt_after_full", 64'(frame_cnt), 64'd1);

    // Extra beat after eof: overflow with held indices (6,3).
    drive(1'b0, 1'b1);
    push_exp(12'd6, 12'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    idle(6);

    // Gapped frame.
    send_run(BPF, 1, 1'b0, 1'b1, BPF);
    idle(6);

    // Back-to-back frames.
    send_run(BPF, 2, 1'b0, 1'b0, BPF);
    send_run(BPF, 3, 1'b0, 1'b0, BPF);
    idle(6);
    @(negedge clk);
    chk("frame_cnt_after_b2b", 64'(frame_cnt), 64'd4);

    // Short frame: restart on beat 5, then complete the new frame.
    send_run(5, 4, 1'b0, 1'b0, 5);
    send_run(BPF, 4, 1'b1, 1'b0, BPF);
    idle(6);
    @(negedge clk);
    chk("frame_cnt_after_short", 64'(frame_cnt), 64'd5);

    // Reset while output beat 7 is due: beats 7..9 are in flight and dropped.
    send_run(10, 5, 1'b0, 1'b0, 7);
    do_reset();
    idle(8);
    send_run(BPF, 0, 1'b0, 1'b0, BPF);
    idle(PD + 4);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("frame_cnt_after_reset_frame", 64'(frame_cnt), 64'd1);

    // Single-pixel frame, zero delay: one-cycle latency, sof/eol/eof together.
    @(posedge clk);
    #1;
    nf2 = 1'b1;
    pv2 = 1'b1;
    @(posedge clk);
    #1;
    nf2 = 1'b0;
    chk("lat1_beat", {x2, y2, cv2, sof2, eol2, eof2, es2, eo2, cnt2},
        {12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1});
    @(posedge clk);
    #1;
    pv2 = 1'b0;
    chk("lat1_overflow", {cv2, sof2, eo2, cnt2}, {1'b0, 1'b0, 1'b1, 16'd1});
    @(posedge clk);
    #1;
    chk("lat1_quiet", {cv2, eo2, es2}, {1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_coord_tracker.md
PIXEL_COORD_TRACKER -- requirements
Module: pixel_coord_tracker

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  IM_WIDTH 640 active pixels per line;
  IM_HEIGHT 480 active lines per frame;
  PROP_DELAY 0 clocks of upstream pipeline latency to compensate, 0..1023;
  PIX_PER_CLK 1 pixels per beat, one of 1/2/4, must divide IM_WIDTH;
  IND_WIDTH 12 bits of the x/y indices;
  CNT_WIDTH 16 bits of the frame counter.
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
  clk in 1 single clock, all logic on its rising edge;
  rst in 1 synchronous, active-high reset;
  new_frame in 1 start of frame, qualified by pix_valid, marks the first beat of a frame;
  pix_valid in 1 beat of PIX_PER_CLK pixels enters the upstream pipeline;
  ind_x out IND_WIDTH x of lane 0 of the output beat, always a multiple of PIX_PER_CLK;
  ind_y out IND_WIDTH line index;
  coord_valid out 1 ind_x/ind_y are valid for this beat;
  sof_out out 1 beat is pixel (0,0);
  eol_out out 1 beat is the last beat of a line;
  eof_out out 1 beat is the last beat of the frame;
  frame_cnt out CNT_WIDTH completed frames, wraps;
  err_short out 1 one-cycle pulse, frame restarted before it completed;
  err_overflow out 1 one-cycle pulse, beat arrived after eof and without new_frame.

Function
REQ-003 pix_valid and (new_frame & pix_valid) SHALL pass through a PROP_DELAY-stage shift register, giving d_valid and d_sof; when PROP_DELAY=0 they are used undelayed.
REQ-004 Outputs SHALL be registered: input beat at cycle t produces output at cycle t+PROP_DELAY+1.
REQ-005 Arbitrary new_frame spacing SHALL be supported, including back-to-back frames; the delay line holds every in-flight event.
REQ-006 The FSM SHALL have three states: IDLE, ACTIVE, DONE.
REQ-007 In any state, d_valid & d_sof SHALL emit (0,0) with coord_valid=1 and sof_out=1, and enter ACTIVE.
REQ-008 In ACTIVE, on d_valid without d_sof:
  - ind_x SHALL advance by PIX_PER_CLK;
  - at ind_x = IM_WIDTH-PIX_PER_CLK, the next beat SHALL have x=0 and y+1.
REQ-009 eol_out SHALL be 1 on the beat with ind_x = IM_WIDTH-PIX_PER_CLK.
REQ-010 eof_out SHALL be 1 when that beat also has ind_y = IM_HEIGHT-1; on eof the FSM SHALL enter DONE and frame_cnt SHALL increment, wrapping at 2^CNT_WIDTH.
REQ-011 In IDLE or DONE, d_valid without d_sof SHALL produce coord_valid=0 and indices held; in DONE it SHALL additionally pulse err_overflow; in IDLE no error is flagged.
REQ-012 d_sof in ACTIVE before eof SHALL pulse err_short in the same cycle as sof_out; frame_cnt is unchanged.
REQ-013 Cycles without d_valid SHALL hold the indices and state, with coord_valid, sof_out, eol_out and eof_out all 0.
REQ-014 Single-line (IM_HEIGHT=1) and single-beat-line (IM_WIDTH=PIX_PER_CLK) configurations SHALL work; eol_out and eof_out may coincide with sof_out.
REQ-015 All index arithmetic SHALL be IND_WIDTH-bit unsigned; elaboration SHALL fail if IM_WIDTH-1 or IM_HEIGHT-1 exceeds 2^IND_WIDTH-1, or if IM_WIDTH mod PIX_PER_CLK is not 0.

Reset
REQ-016 rst SHALL clear the delay line, return the FSM to IDLE, and zero every output including frame_cnt.
REQ-017 Beats in flight at reset SHALL be discarded; the first d_valid after reset is examined no sooner than PROP_DELAY+1 cycles after input.
REQ-018 rst asserted mid-frame SHALL flag no error; a new frame SHALL start only on a subsequent new_frame.

Structure
REQ-019 Package pixel_coord_pkg SHALL hold the state enum (IDLE, ACTIVE, DONE) and the helper constant BEATS_PER_LINE = IM_WIDTH/PIX_PER_CLK.
REQ-020 The delay line SHALL be the sub-module sig_delay_line, with parameters WIDTH=2 and DEPTH=PROP_DELAY, synchronous reset, and a pass-through wire at DEPTH=0.

Verification (IM_WIDTH=8, IM_HEIGHT=4, PIX_PER_CLK=2, PROP_DELAY=3 unless noted)
REQ-021 Full frame, 16 contiguous beats with new_frame on beat 0 -> sof_out at cycle 4 with (0,0); eol_out at x=6 for y=0..3; eof_out at (6,3) on cycle 19; frame_cnt=1.
REQ-022 Gapped frame, pix_valid 1/0 alternating -> coordinates identical to REQ-021, coord_valid only on odd output cycles, indices held during gaps.
REQ-023 Back-to-back frames, second new_frame on the cycle after the first frame's last beat -> eof then sof on consecutive output cycles, frame_cnt=2, no errors.
REQ-024 Short frame, new_frame on beat 5 -> err_short and sof_out in the same cycle, outputs (0,0), frame_cnt unchanged.
REQ-025 Overflow, 17th beat without new_frame -> err_overflow pulse, coord_valid=0; beats before the first new_frame after reset -> no outputs, no errors.
REQ-026 Reset at output beat 7, then a new frame -> all outputs 0 within one cycle, no stale beats emitted; with PROP_DELAY=0 and PIX_PER_CLK=1, latency SHALL be 1 cycle.
